// File: rtl/bitrev_reorder_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bitrev_reorder_buf (+ helper gen_shuffle_idx)               |
// | Description : Ping-pong reorder buffer. It accepts a bit-reversed FFT     |
// |               output stream and emits 2^N-sample frames in natural        |
// |               order, with valid/ready on both sides.                      |
// | Option      : BITREV_FRAME_CNT_EN adds a 16-bit completed-frame counter.  |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+

// Constant table. shuffle_idx[k] is the N-bit bit reversal of k.
module gen_shuffle_idx #(
  parameter int N = 4
) (
  output logic [N-1:0] shuffle_idx [2**N]
);
  for (genvar k = 0; k < 2**N; k++) begin : g_idx
    for (genvar b = 0; b < N; b++) begin : g_bit
      // Bit b of the index is taken from bit N-1-b of k.
      assign shuffle_idx[k][b] = ((k >> (N - 1 - b)) & 1) != 0;
    end
  end
endmodule

module bitrev_reorder_buf #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic         out_first,
`ifdef BITREV_FRAME_CNT_EN
  output logic [15:0]  frame_cnt,
`endif
  output logic         out_last
);

  localparam logic [N-1:0] LAST_IDX = '1;

  logic [N-1:0]   shuffle_idx [2**N];
  logic [2*W-1:0] mem [2][2**N];

  logic [1:0]   bank_full;
  logic [1:0]   bank_full_nxt;
  logic         wbank;
  logic         rbank;
  logic [N-1:0] wcnt;
  logic [N-1:0] rcnt;

  logic wr_fire;
  logic wr_done;
  logic rd_adv;
  logic rd_done;

  gen_shuffle_idx #(.N(N)) u_shuffle (
    .shuffle_idx(shuffle_idx)
  );

  // A bank that is still waiting to be read blocks the writer. This depends
  // only on registered state and rst.
  assign in_ready = !rst && !bank_full[wbank];

  assign wr_fire = in_valid && in_ready;
  assign wr_done = wr_fire && (wcnt == LAST_IDX);
  assign rd_adv  = bank_full[rbank] && (!out_valid || out_ready);
  assign rd_done = rd_adv && (rcnt == LAST_IDX);

  // Merge fill and release. When both happen in one cycle they target
  // different banks.
  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_done) bank_full_nxt[wbank] = 1'b1;
    if (rd_done) bank_full_nxt[rbank] = 1'b0;
  end

  // Sample storage. This block has no reset, so stale data is simply
  // overwritten by the next frame.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wbank][shuffle_idx[wcnt]] <= {in_re, in_im};
  end

  // Bank ownership and the write and read counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full <= 2'b00;
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      wcnt      <= '0;
      rcnt      <= '0;
    end else begin
      bank_full <= bank_full_nxt;
      if (wr_fire) begin
        wcnt <= wcnt + 1'b1;
        if (wr_done) wbank <= ~wbank;
      end
      if (rd_adv) begin
        rcnt <= rcnt + 1'b1;
        if (rd_done) rbank <= ~rbank;
      end
    end
  end

  // Registered output stage. It reloads on advance, empties when the
  // downstream takes the sample, and otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else if (rd_adv) begin
      {out_re, out_im} <= mem[rbank][rcnt];
      out_valid        <= 1'b1;
      out_first        <= (rcnt == '0);
      out_last         <= (rcnt == LAST_IDX);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef BITREV_FRAME_CNT_EN
  // Count frames whose final sample the downstream has taken.
  always_ff @(posedge clk) begin
    if (rst) frame_cnt <= 16'd0;
    else if (out_valid && out_ready && out_last) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bitrev_reorder_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_bitrev_reorder_buf                                      |
// | Description : Self-checking bench for bitrev_reorder_buf (N=4, W=16).    |
// |               It compares the DUT against a frame-level reference model. |
// | Option      : BITREV_FRAME_CNT_EN also checks frame_cnt.                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_bitrev_reorder_buf;
  localparam int N = 4;
  localparam int W = 16;
  localparam int F = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_re = '0;
  logic [W-1:0] in_im = '0;
  wire          in_ready, out_valid, out_first, out_last;
  wire  [W-1:0] out_re, out_im;
`ifdef BITREV_FRAME_CNT_EN
  wire  [15:0]  frame_cnt;
`endif

  bitrev_reorder_buf #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_first(out_first),
`ifdef BITREV_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    bit           first;
    bit           last;
  } smp_t;

  smp_t         exp_q[$];
  smp_t         mon_s;
  logic [W-1:0] part_re [F];
  logic [W-1:0] part_im [F];
  int           part_n = 0;
  bit           mon_en = 0;
  int           n_acc = 0;
  int           n_out = 0;
  int           mon_fc = 0;

  function automatic int brev(input int k);
    int r = 0;
    for (int b = 0; b < N; b++) r = r * 2 + ((k >> b) & 1);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model. Handshakes are observed at mid-cycle, one half period
  // before the edge that completes them. Each complete input frame is
  // permuted into natural order: natural index j comes from input k = brev(j).
  always @(negedge clk) begin
    if (mon_en) begin
`ifdef BITREV_FRAME_CNT_EN
      check("frame_cnt", 32'(frame_cnt), 32'(mon_fc));
`endif
      if (rst) begin
        exp_q.delete();
        part_n = 0;
        mon_fc = 0;
      end else begin
        if (in_valid && in_ready) begin
          part_re[part_n] = in_re;
          part_im[part_n] = in_im;
          part_n++;
          n_acc++;
          if (part_n == F) begin
            for (int j = 0; j < F; j++)
              exp_q.push_back('{part_re[brev(j)], part_im[brev(j)], j == 0, j == F - 1});
            part_n = 0;
          end
        end
        if (out_valid && out_ready) begin
          n_out++;
          if (out_last) mon_fc = (mon_fc + 1) % 65536;
          if (exp_q.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
          end else begin
            mon_s = exp_q.pop_front();
            check("out_sample", {out_re, out_im}, {mon_s.re, mon_s.im});
            check("out_flags", {30'd0, out_first, out_last}, {30'd0, mon_s.first, mon_s.last});
          end
        end
      end
    end
  end

  typedef struct {
    bit           iv;
    logic [W-1:0] re;
    logic [W-1:0] im;
    bit           x_ov;
    logic [W-1:0] x_re;
    logic [W-1:0] x_im;
    bit           x_first;
    bit           x_last;
  } vec_t;
  vec_t vt [33];

  task automatic drain(input int bound);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    check("drain_done", 32'(exp_q.size()) + {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, hs, first_v, last_v, tot_v, start_acc, start_out;

    // Reset values.
    rst = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_first_last", {30'd0, out_first, out_last}, 32'd0);
    check("rst_data", {out_re, out_im}, 32'd0);
`ifdef BITREV_FRAME_CNT_EN
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
    mon_en = 1;

    // Natural-order check, table driven. Input k carries re=brev(k), im=k.
    // The first output appears one cycle after the 16th input is accepted.
    for (int c = 0; c < 33; c++) begin
      vt[c].iv      = (c < 16);
      vt[c].re      = 16'(brev(c % 16));
      vt[c].im      = 16'(c % 16);
      vt[c].x_ov    = (c >= 16 && c <= 31);
      vt[c].x_re    = 16'((c - 16) & 15);
      vt[c].x_im    = 16'(brev((c - 16) & 15));
      vt[c].x_first = (c == 16);
      vt[c].x_last  = (c == 31);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 33; c++) begin
      in_valid = vt[c].iv;
      in_re    = vt[c].re;
      in_im    = vt[c].im;
      #1;
      check("nat_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      check("nat_out_valid", {31'd0, out_valid}, {31'd0, vt[c].x_ov});
      if (vt[c].x_ov) begin
        check("nat_out_data", {out_re, out_im}, {vt[c].x_re, vt[c].x_im});
        check("nat_out_flags", {30'd0, out_first, out_last}, {30'd0, vt[c].x_first, vt[c].x_last});
      end
    end
    in_valid = 1'b0;

    // Back-to-back: three frames streamed continuously.
    first_v = -1; last_v = -1; tot_v = 0;
    for (int c = 0; c < 70; c++) begin
      in_valid = (c < 48);
      in_re    = 16'($urandom);
      in_im    = 16'($urandom);
      #1;
      if (c < 48) check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      if (out_valid) begin
        if (first_v < 0) first_v = c;
        last_v = c;
        tot_v++;
      end
    end
    in_valid = 1'b0;
    check("b2b_valid_count", 32'(tot_v), 32'd48);
    check("b2b_valid_span", 32'(last_v - first_v + 1), 32'd48);
    drain(50);

    // Backpressure: offer 40 samples with out_ready low.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_re    = 16'(brev(i % 16));
      in_im    = 16'(i);
      #1;
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("bp_accepted", 32'(acc), 32'd32);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_data", {out_re, out_im}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 100 && hs < 16; i++) begin
      if (out_valid) hs++;
      tick();
    end
    check("bp_hs16", 32'(hs), 32'd16);
    check("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    drain(100);

    // Random stalls over ten frames.
    start_acc = n_acc;
    start_out = n_out;
    for (int i = 0; i < 6000; i++) begin
      if (n_acc - start_acc >= 160 && exp_q.size() == 0 && !out_valid) break;
      in_valid  = (n_acc - start_acc < 160) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_re     = 16'($urandom);
      in_im     = 16'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    check("rnd_accepted", 32'(n_acc - start_acc), 32'd160);
    check("rnd_emitted", 32'(n_out - start_out), 32'd160);
    drain(100);

    // Reset mid-frame: frame 1 is half drained and frame 2 has 7 samples.
    out_ready = 1'b1;
    for (int i = 0; i < 23; i++) begin
      in_valid = 1'b1;
      in_re    = 16'($urandom);
      in_im    = 16'($urandom);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef BITREV_FRAME_CNT_EN
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready_back", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_re    = 16'(brev(k));
      in_im    = 16'(k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("fresh_first", {30'd0, out_valid, out_first}, 32'd3);
    check("fresh_data0", {out_re, out_im}, 32'd0);

    // Two more frames, so three in total have been sent since the reset.
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      in_re    = 16'($urandom);
      in_im    = 16'($urandom);
      tick();
    end
    in_valid = 1'b0;
    drain(100);
    tick();
`ifdef BITREV_FRAME_CNT_EN
    check("frame_cnt_3", 32'(frame_cnt), 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
